// File: rtl/poly_inverse_search_if.sv
// Operand/result bundle for the quadratic inverse search.
// Combinational wiring only; no latency.
// No backpressure: go is a level-sensitive press/release handshake.
interface poly_inverse_search_if #(
  parameter int WIDTH = 8
);
  logic             go;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] x_result;
  logic             found;
  logic             done;
  logic             busy;

  // Board/driver side: presses go, presents operands, watches results
  modport master (
    output go,
    output data_in,
    input  x_result,
    input  found,
    input  done,
    input  busy
  );

  // Search engine side
  modport slave (
    input  go,
    input  data_in,
    output x_result,
    output found,
    output done,
    output busy
  );
endinterface

// File: rtl/poly_inverse_search.sv
// Finds the smallest x with C*x*x + B*x + A == Y (mod 2^WIDTH) using one shared add/multiply ALU.
// Latency: 4 cycles per candidate; a match at x=k shows done 4*(k+1) cycles after the first EVAL0.
// No backpressure: operands are confirmed by go press/release; go and data_in are ignored while searching.
module poly_inverse_search #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  poly_inverse_search_if.slave bus
);

  localparam logic [3:0] LOAD_A      = 4'd0;
  localparam logic [3:0] LOAD_A_WAIT = 4'd1;
  localparam logic [3:0] LOAD_B      = 4'd2;
  localparam logic [3:0] LOAD_B_WAIT = 4'd3;
  localparam logic [3:0] LOAD_C      = 4'd4;
  localparam logic [3:0] LOAD_C_WAIT = 4'd5;
  localparam logic [3:0] LOAD_Y      = 4'd6;
  localparam logic [3:0] LOAD_Y_WAIT = 4'd7;
  localparam logic [3:0] EVAL0       = 4'd8;
  localparam logic [3:0] EVAL1       = 4'd9;
  localparam logic [3:0] EVAL2       = 4'd10;
  localparam logic [3:0] EVAL3       = 4'd11;
  localparam logic [3:0] DONE        = 4'd12;
  localparam logic [3:0] DONE_WAIT   = 4'd13;

  logic [3:0]       state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] x_result_r;
  logic             found_r;
  logic             done_r;
  logic [WIDTH-1:0] poly_val;

  // Final Horner step: (c*x + b)*x already sits in acc, so adding a completes the polynomial.
  // The sum is kept WIDTH bits wide so the comparison is modulo 2^WIDTH.
  assign poly_val = acc + a;

  assign bus.x_result = x_result_r;
  assign bus.found    = found_r;
  assign bus.done     = done_r;
  assign bus.busy     = (state == EVAL0) || (state == EVAL1) ||
                        (state == EVAL2) || (state == EVAL3);

  // Operand loading, Horner evaluation of each candidate, and result handshake
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= LOAD_A;
      a          <= '0;
      b          <= '0;
      c          <= '0;
      y          <= '0;
      x          <= '0;
      acc        <= '0;
      x_result_r <= '0;
      found_r    <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      case (state)
        // Each LOAD state tracks data_in every clock, so the value held is the
        // one present on the edge where go is first seen high.
        LOAD_A: begin
          a <= bus.data_in;
          if (bus.go) state <= LOAD_A_WAIT;
        end
        LOAD_A_WAIT: if (!bus.go) state <= LOAD_B;
        LOAD_B: begin
          b <= bus.data_in;
          if (bus.go) state <= LOAD_B_WAIT;
        end
        LOAD_B_WAIT: if (!bus.go) state <= LOAD_C;
        LOAD_C: begin
          c <= bus.data_in;
          if (bus.go) state <= LOAD_C_WAIT;
        end
        LOAD_C_WAIT: if (!bus.go) state <= LOAD_Y;
        LOAD_Y: begin
          y <= bus.data_in;
          if (bus.go) state <= LOAD_Y_WAIT;
        end
        LOAD_Y_WAIT: begin
          if (!bus.go) begin
            x     <= '0;
            state <= EVAL0;
          end
        end
        EVAL0: begin
          acc   <= c * x;
          state <= EVAL1;
        end
        EVAL1: begin
          acc   <= acc + b;
          state <= EVAL2;
        end
        EVAL2: begin
          acc   <= acc * x;
          state <= EVAL3;
        end
        EVAL3: begin
          if (poly_val == y) begin
            x_result_r <= x;
            found_r    <= 1'b1;
            done_r     <= 1'b1;
            state      <= DONE;
          end else if (x == '1) begin
            // Whole candidate space exhausted without a hit
            x_result_r <= '0;
            found_r    <= 1'b0;
            done_r     <= 1'b1;
            state      <= DONE;
          end else begin
            x     <= x + WIDTH'(1);
            state <= EVAL0;
          end
        end
        // Result acknowledged: flags drop, x_result stays until the next search completes
        DONE: begin
          if (bus.go) begin
            done_r  <= 1'b0;
            found_r <= 1'b0;
            state   <= DONE_WAIT;
          end
        end
        DONE_WAIT: if (!bus.go) state <= LOAD_A;
        default: state <= LOAD_A;
      endcase
    end
  end

endmodule
